// File: rtl/uart_sender_pkg.sv
// Shared types and helpers for the UART data sender: FSM state encoding,
// ASCII constants and the nibble-to-hex-character conversion.
package uart_sender_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_HI,
    WAIT_LO
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit for one nibble: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_A + {4'h0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/sender_tick_gen.sv
// Free-running period counter producing a one-cycle tick every PERIOD
// clocks. Used only when UART_SENDER_AUTO_EN is defined.
module sender_tick_gen #(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  // A period below 2 cannot be counted meaningfully; clamp it.
  localparam int unsigned P = (PERIOD < 2) ? 2 : PERIOD;
  localparam int unsigned W = $clog2(P);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == W'(P - 1));

  // Wrap to zero on the tick, otherwise count up.
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_data_sender.sv
// Converts a captured 16-bit word into a 4-digit uppercase hex ASCII frame
// (optionally followed by CR LF) and streams it into uart_tx through a
// start/busy handshake.
// Optional: define UART_SENDER_AUTO_EN to add a periodic auto-send request.
module uart_data_sender
  import uart_sender_pkg::*;
#(
  parameter int unsigned CRLF_EN        = 1,
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned AUTO_PERIOD_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] send_data,
  input  logic        start,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        sender_busy,
  output logic        frame_done
);

  localparam logic [2:0] LAST_IDX = (CRLF_EN != 0) ? 3'd5 : 3'd3;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cap_q, cap_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cur_byte;
  logic        req;

`ifdef UART_SENDER_AUTO_EN
  localparam int unsigned AUTO_TICKS = CLK_FREQ / 1000 * AUTO_PERIOD_MS;

  logic auto_tick;

  sender_tick_gen #(
    .PERIOD(AUTO_TICKS)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .tick_o(auto_tick)
  );

  assign req = start | auto_tick;
`else
  assign req = start;
`endif

  // Select the frame byte addressed by the current index.
  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = nibble_to_ascii(cap_q[15:12]);
      3'd1:    cur_byte = nibble_to_ascii(cap_q[11:8]);
      3'd2:    cur_byte = nibble_to_ascii(cap_q[7:4]);
      3'd3:    cur_byte = nibble_to_ascii(cap_q[3:0]);
      3'd4:    cur_byte = ASCII_CR;
      default: cur_byte = ASCII_LF;
    endcase
  end

  // Next-state and output decode for the send sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // The frame_done cycle is still IDLE, but a request there is dropped.
        if (req && !done_q) begin
          cap_d   = send_data;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cap_q      <= 16'h0000;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign sender_busy = busy_q;
  assign frame_done  = done_q;

endmodule
